// File: rtl/md_issue_ctrl_if.sv
`default_nettype none
// =============================================================================
// md_issue_ctrl_if : E-stage request and MD-unit signal bundle for md_issue_ctrl
// Revision: 1.0
// =============================================================================
interface md_issue_ctrl_if;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        stall;
  logic [7:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [7:0]  md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        rd_valid;
  logic [31:0] rd_data;

  // master: the issue controller; slave: pipeline plus MD unit around it
  modport master (
    input  in_valid, in_op, in_a, in_b, md_busy, md_hi, md_lo,
    output stall, md_op, md_a, md_b, rd_valid, rd_data
  );

  modport slave (
    output in_valid, in_op, in_a, in_b, md_busy, md_hi, md_lo,
    input  stall, md_op, md_a, md_b, rd_valid, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// =============================================================================
// md_issue_ctrl : E-stage requester for the HI/LO multiply-divide unit.
// Optional watchdog on the busy wait enabled by defining MD_WATCHDOG_EN.
// Revision: 1.0
// =============================================================================
module md_issue_ctrl #(
  parameter int WATCHDOG = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,
  md_issue_ctrl_if.master bus,
  output logic            md_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ARM   = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [7:0] MD_MTHI  = 8'd28;
  localparam logic [7:0] MD_MTLO  = 8'd29;

  state_t      state;
  logic [7:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        is_md;
  logic        is_read;
  logic        hilo_pend;

  assign is_md     = (bus.in_op >= OP_MULT) && (bus.in_op <= OP_MFLO);
  assign is_read   = (bus.in_op == OP_MFHI) || (bus.in_op == OP_MFLO);
  // HI/LO are written on the edge that ends an mthi/mtlo cycle, so a read must wait one cycle
  assign hilo_pend = (md_op == MD_MTHI) || (md_op == MD_MTLO);

  assign bus.stall = reset && bus.in_valid && is_md &&
                     ((state != IDLE) || (hilo_pend && is_read));

  assign bus.md_op    = md_op;
  assign bus.md_a     = md_a;
  assign bus.md_b     = md_b;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_data;

`ifdef MD_WATCHDOG_EN
  localparam logic [4:0] WD_LIMIT = 5'(WATCHDOG);
  logic [4:0] wdog;
`else
  logic unused_watchdog;
  assign unused_watchdog = (WATCHDOG != 0);
  assign md_err          = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      md_op    <= 8'd0;
      md_a     <= 32'd0;
      md_b     <= 32'd0;
      rd_valid <= 1'b0;
      rd_data  <= 32'd0;
`ifdef MD_WATCHDOG_EN
      wdog     <= 5'd0;
      md_err   <= 1'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          md_op <= 8'd0;
          if (bus.in_valid && !bus.stall) begin
            case (bus.in_op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                md_op <= {4'd0, bus.in_op} + 8'd23;
                md_a  <= bus.in_a;
                md_b  <= bus.in_b;
                state <= ISSUE;
              end
              OP_MTHI, OP_MTLO: begin
                md_op <= (bus.in_op == OP_MTHI) ? MD_MTHI : MD_MTLO;
                md_a  <= bus.in_a;
                md_b  <= bus.in_b;
              end
              OP_MFHI: begin
                rd_valid <= 1'b1;
                rd_data  <= bus.md_hi;
              end
              OP_MFLO: begin
                rd_valid <= 1'b1;
                rd_data  <= bus.md_lo;
              end
              default: ;
            endcase
          end
        end
        ISSUE: begin
          md_op <= 8'd0;
          state <= ARM;
        end
        ARM: begin
          // the unit has not loaded its busy count yet
          state <= WAIT;
`ifdef MD_WATCHDOG_EN
          wdog  <= 5'd0;
`endif
        end
        WAIT: begin
          if (bus.md_busy == 8'd0) begin
            state <= IDLE;
`ifdef MD_WATCHDOG_EN
          end else if (wdog == WD_LIMIT) begin
            md_err <= 1'b1;
            state  <= IDLE;
          end else begin
            wdog <= wdog + 5'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
`default_nettype none
// =============================================================================
// tb_md_issue_ctrl : scoreboard bench with a behavioural MD unit and an
// architectural HI/LO model for md_issue_ctrl.
// Revision: 1.0
// =============================================================================
module tb_md_issue_ctrl;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic md_err;

  md_issue_ctrl_if bus ();

  md_issue_ctrl #(.WATCHDOG(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .md_err (md_err)
  );

  always #5 clk = ~clk;

  op_t         exp_op[$];
  logic [31:0] exp_rd[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          lat = 3;
  bit          stuck = 1'b0;
  logic [63:0] pend;

  function automatic logic [63:0] md_result(input logic [7:0] code, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    case (code)
      8'd24:   r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      8'd25:   r = {32'd0, a} * {32'd0, b};
      8'd26:   r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      8'd27:   r = {a % b, a / b};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Behavioural MD unit: loads busy one edge after the op, writes HI/LO when it counts out
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.md_busy <= 8'd0;
      bus.md_hi   <= 32'd0;
      bus.md_lo   <= 32'd0;
      pend        <= 64'd0;
    end else begin
      if (bus.md_op >= 8'd24 && bus.md_op <= 8'd27) begin
        pend        <= md_result(bus.md_op, bus.md_a, bus.md_b);
        bus.md_busy <= 8'(lat);
      end else if (!stuck && bus.md_busy > 8'd1) begin
        bus.md_busy <= bus.md_busy - 8'd1;
      end else if (!stuck && bus.md_busy == 8'd1) begin
        bus.md_busy <= 8'd0;
        bus.md_hi   <= pend[63:32];
        bus.md_lo   <= pend[31:0];
      end
      if (bus.md_op == 8'd28) bus.md_hi <= bus.md_a;
      if (bus.md_op == 8'd29) bus.md_lo <= bus.md_a;
    end
  end

  // Architectural model: program-order HI/LO and the MD commands each instruction must produce
  task automatic model_accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op_t         e;
    logic [63:0] r;
    case (op)
      4'd1, 4'd2, 4'd3, 4'd4: begin
        e.op = {4'd0, op} + 8'd23; e.a = a; e.b = b;
        exp_op.push_back(e);
        r = md_result(e.op, a, b);
        m_hi = r[63:32];
        m_lo = r[31:0];
      end
      4'd5: begin e.op = 8'd28; e.a = a; e.b = b; exp_op.push_back(e); m_hi = a; end
      4'd6: begin e.op = 8'd29; e.a = a; e.b = b; exp_op.push_back(e); m_lo = a; end
      4'd7: exp_rd.push_back(m_hi);
      4'd8: exp_rd.push_back(m_lo);
      default: ;
    endcase
  endtask

  task automatic mon_step();
    op_t         e;
    logic [31:0] d;
    if (bus.md_op != 8'd0) begin
      if (exp_op.size() == 0) begin
        n_total++;
        $display("FAIL md_op_unexpected: got %0d, expected no command", bus.md_op);
      end else begin
        e = exp_op.pop_front();
        check("md_op", {24'd0, bus.md_op}, {24'd0, e.op});
        check("md_a", bus.md_a, e.a);
        if (e.op < 8'd28) check("md_b", bus.md_b, e.b);
      end
    end
    if (bus.rd_valid === 1'b1) begin
      if (exp_rd.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: got rd_data 0x%08h, expected no read", bus.rd_data);
      end else begin
        d = exp_rd.pop_front();
        check("rd_data", bus.rd_data, d);
      end
    end
  endtask

  always @(negedge clk) if (reset) mon_step();

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int stalls);
    bit md;
    md = (op >= 4'd1 && op <= 4'd8);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
    stalls = 0;
    @(negedge clk);
    while (bus.stall === 1'b1 && stalls < 100) begin stalls++; @(negedge clk); end
    if (stalls >= 100) begin
      n_total++;
      $display("FAIL accept_timeout: op %0d stalled %0d cycles, expected acceptance", op, stalls);
    end else begin
      if (!md) check("noop_stall", 32'(stalls), 32'd0);
      model_accept(op, a, b);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_op = 4'd0;
  endtask

  task automatic model_reset();
    m_hi = 32'd0; m_lo = 32'd0;
    exp_op.delete(); exp_rd.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int s;
    bus.in_valid = 1'b1; bus.in_op = 4'd1; bus.in_a = 32'd0; bus.in_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_md_op", {24'd0, bus.md_op}, 32'd0);
    check("rst_md_a", bus.md_a, 32'd0);
    check("rst_md_b", bus.md_b, 32'd0);
    check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_md_err", {31'd0, md_err}, 32'd0);
    bus.in_valid = 1'b0; bus.in_op = 4'd0;
    reset = 1'b1;
    idle(2);

    // mult -3*7, busy 5..1; mflo stalls through ISSUE, ARM and five WAIT cycles
    lat = 5;
    issue(4'd1, 32'hFFFF_FFFD, 32'd7, s);
    issue(4'd8, 32'd0, 32'd0, s);
    check("mflo_after_mult_stall", 32'(s), 32'd7);
    issue(4'd7, 32'd0, 32'd0, s);
    check("mfhi_idle_stall", 32'(s), 32'd0);

    // divu 100/7 with non-MD traffic flowing during the wait
    lat = 10;
    issue(4'd4, 32'd100, 32'd7, s);
    issue(4'd0, 32'd1, 32'd2, s);
    issue(4'd9, 32'd3, 32'd4, s);
    issue(4'd15, 32'd5, 32'd6, s);
    issue(4'd8, 32'd0, 32'd0, s);
    check("mflo_after_divu_stall", 32'(s), 32'd9);
    issue(4'd7, 32'd0, 32'd0, s);

    // mtlo then mflo back-to-back
    issue(4'd6, 32'h0000_1234, 32'd0, s);
    issue(4'd8, 32'd0, 32'd0, s);
    check("mflo_after_mtlo_stall", 32'(s), 32'd1);

    // two consecutive mults
    lat = 4;
    issue(4'd1, 32'd11, 32'd13, s);
    issue(4'd2, 32'hFFFF_0000, 32'h0001_0001, s);
    check("mult_b2b_stall", 32'(s), 32'd6);
    issue(4'd7, 32'd0, 32'd0, s);
    issue(4'd8, 32'd0, 32'd0, s);

    // reset while waiting with busy at 3
    lat = 6;
    issue(4'd1, 32'd5, 32'd9, s);
    idle(4);
    bus.in_valid = 1'b1; bus.in_op = 4'd1;
    #1;
    check("wait_stall", {31'd0, bus.stall}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_mid_md_op", {24'd0, bus.md_op}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_op = 4'd0;
    reset = 1'b1;
    idle(1);
    issue(4'd7, 32'd0, 32'd0, s);

    // randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          k;
      k = $urandom_range(0, 15);
      if (k < 12)      op = 4'($urandom_range(1, 8));
      else if (k < 15) op = 4'($urandom_range(9, 15));
      else             op = 4'd0;
      a = $urandom;
      b = $urandom;
      if (op == 4'd3 || op == 4'd4) begin
        b = 32'($urandom_range(1, 5000));
        if (op == 4'd3 && $urandom_range(0, 1) == 1) b = -b;
      end
      lat = $urandom_range(1, 12);
      issue(op, a, b, s);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(30);
    check("drain_md_op", 32'(exp_op.size()), 32'd0);
    check("drain_rd", 32'(exp_rd.size()), 32'd0);

`ifdef MD_WATCHDOG_EN
    begin
      int c;
      stuck = 1'b1; lat = 4;
      issue(4'd1, 32'd3, 32'd3, s);
      c = 0;
      while (md_err !== 1'b1 && c < 60) begin @(negedge clk); c++; end
      check("wdog_err", {31'd0, md_err}, 32'd1);
      check("wdog_latency_in_range", {31'd0, (c >= 19 && c <= 21)}, 32'd1);
      idle(5);
      check("wdog_err_sticky", {31'd0, md_err}, 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_op = 4'd1;
      #1;
      check("wdog_idle_stall", {31'd0, bus.stall}, 32'd0);
      bus.in_valid = 1'b0; bus.in_op = 4'd0;
      reset = 1'b0;
      #1;
      check("wdog_err_cleared", {31'd0, md_err}, 32'd0);
      model_reset();
      stuck = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      idle(2);
    end
`else
    check("md_err_tied", {31'd0, md_err}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
